// File: rtl/mac_arbiter.sv
// mac_arbiter: round-robin arbiter that lets NREQ requesters share a single
// multiply-offset datapath. It computes
//   resp_data = ((a*b mod 2^WIDTH) + ADD_K - SUB_K) mod 2^WIDTH.
// One request is in flight at a time. A grant in cycle T produces resp_valid
// in cycle T+2. The next grant can happen at the earliest in the cycle after
// the response handshake.
//
// Ports
//   clk         single clock; all state changes on its rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   [NREQ]        requester i presents an operand pair
//   req_a/req_b [NREQ*WIDTH]  operands, requester i in [i*WIDTH +: WIDTH]
//   req_ready   [NREQ]        one-hot grant, combinational, only in IDLE
//   resp_valid                result held for the consumer
//   resp_ready                consumer accepts the result
//   resp_data   [WIDTH]       result; zero while resp_valid is low
//   resp_id     [clog2(NREQ)] owner of resp_data; zero while resp_valid is low
//   busy                      high in any state other than IDLE
//
// state | meaning
// IDLE  | arbitrating; grant the first valid requester at or above ptr
// CALC  | operands captured; compute and register the result
// HOLD  | resp_valid high until resp_ready is sampled high

module mac_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int ADD_K = 17,
  parameter int SUB_K = 21
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*WIDTH-1:0]      req_a,
  input  logic [NREQ*WIDTH-1:0]      req_b,
  output logic [NREQ-1:0]            req_ready,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [WIDTH-1:0]           resp_data,
  output logic [$clog2(NREQ)-1:0]    resp_id,
  output logic                       busy
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IDW-1:0]   id_r;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW:0]     idx_sum;
  logic [IDW-1:0]   ptr_next;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] calc_res;

  // Rotating search starting at ptr. One extra bit on idx_sum keeps
  // ptr+k from overflowing before the modulo fold, which also makes
  // non-power-of-two NREQ work.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_sum     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_sum = {1'b0, ptr} + (IDW+1)'(k);
      if (idx_sum >= (IDW+1)'(NREQ)) idx_sum = idx_sum - (IDW+1)'(NREQ);
      if (!grant_found && req_valid[idx_sum[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx_sum[IDW-1:0];
      end
    end
  end

  // rst_n is included here so that req_ready is zero during reset
  // even when requesters are already valid.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == IDLE) && grant_found) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Truncate the product first, then apply the offsets with wraparound.
  always_comb begin
    prod     = a_r * b_r;
    calc_res = prod + WIDTH'(ADD_K) - WIDTH'(SUB_K);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      a_r        <= '0;
      b_r        <= '0;
      id_r       <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            a_r   <= req_a[grant_idx*WIDTH +: WIDTH];
            b_r   <= req_b[grant_idx*WIDTH +: WIDTH];
            id_r  <= grant_idx;
            ptr   <= ptr_next;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          resp_data  <= calc_res;
          resp_id    <= id_r;
          resp_valid <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_arbiter.sv
// Directed bench for mac_arbiter (NREQ=4, WIDTH=8, ADD_K=17, SUB_K=21).
// Inputs change just after the falling edge, and outputs are checked 1 ns later.
module tb_mac_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_data;
  logic [1:0]  resp_id;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mac_arbiter #(.NREQ(4), .WIDTH(8), .ADD_K(17), .SUB_K(21)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic scramble();
    req_a = $urandom;
    req_b = $urandom;
  endtask

  initial begin
    logic [3:0] onehot;

    vecs[0] = '{id: 1, a: 8'd3,   b: 8'd5,   exp: 8'd11};
    vecs[1] = '{id: 0, a: 8'd16,  b: 8'd16,  exp: 8'd252};
    vecs[2] = '{id: 2, a: 8'd0,   b: 8'd0,   exp: 8'd252};
    vecs[3] = '{id: 3, a: 8'd255, b: 8'd255, exp: 8'd253};
    vecs[4] = '{id: 0, a: 8'd7,   b: 8'd9,   exp: 8'd59};
    vecs[5] = '{id: 3, a: 8'd200, b: 8'd3,   exp: 8'd84};

    rst_n      = 1'b0;
    req_valid  = 4'hF;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_id", resp_id, 0);
    chk("rst_busy", busy, 0);

    // Grant order with all four requesters valid from reset.
    for (int c = 0; c < 15; c++) begin
      step();
      if (c == 0) rst_n = 1'b1;
      #1;
      if (c % 3 == 0) chk("rr_grant", req_ready, 4'b0001 << ((c / 3) % 4));
      else            chk("rr_nogrant", req_ready, 0);
    end
    step();
    req_valid = 4'h0;
    step();
    step();
    step();
    #1;
    chk("rr_drained_busy", busy, 0);

    // Single-requester transactions taken from the vector table.
    for (int v = 0; v < 6; v++) begin
      step();
      onehot = 4'b0001 << vecs[v].id;
      req_valid = onehot;
      set_op(vecs[v].id, vecs[v].a, vecs[v].b);
      resp_ready = 1'b1;
      #1;
      chk("vec_grant", req_ready, onehot);
      chk("vec_busy_T", busy, 0);
      step();
      req_valid = 4'h0;
      scramble();
      #1;
      chk("vec_busy_T1", busy, 1);
      chk("vec_valid_T1", resp_valid, 0);
      chk("vec_data_T1", resp_data, 0);
      step();
      #1;
      chk("vec_valid_T2", resp_valid, 1);
      chk("vec_data_T2", resp_data, vecs[v].exp);
      chk("vec_id_T2", resp_id, vecs[v].id);
      chk("vec_busy_T2", busy, 1);
      step();
      #1;
      chk("vec_valid_T3", resp_valid, 0);
      chk("vec_data_T3", resp_data, 0);
      chk("vec_id_T3", resp_id, 0);
      chk("vec_busy_T3", busy, 0);
    end

    // Backpressure in HOLD: requester 2 from ptr 0, consumer stalls for 5 cycles.
    step();
    rst_n = 1'b0;
    req_valid = 4'h0;
    step();
    rst_n = 1'b1;
    req_valid = 4'b0100;
    set_op(2, 8'd20, 8'd14);
    resp_ready = 1'b0;
    #1;
    chk("bp_grant", req_ready, 4'b0100);
    step();
    req_valid = 4'b1011;
    scramble();
    #1;
    chk("bp_calc_ready", req_ready, 0);
    for (int c = 0; c < 5; c++) begin
      step();
      scramble();
      #1;
      chk("bp_hold_valid", resp_valid, 1);
      chk("bp_hold_data", resp_data, 20);
      chk("bp_hold_id", resp_id, 2);
      chk("bp_hold_ready", req_ready, 0);
    end
    step();
    resp_ready = 1'b1;
    #1;
    chk("bp_hs_valid", resp_valid, 1);
    chk("bp_hs_data", resp_data, 20);
    chk("bp_hs_ready", req_ready, 0);
    step();
    #1;
    chk("bp_next_grant", req_ready, 4'b1000);
    chk("bp_next_valid", resp_valid, 0);
    step();
    req_valid = 4'h0;
    step();
    step();

    // Reset during CALC: the in-flight request is discarded and ptr returns to 0.
    step();
    req_valid = 4'b0100;
    #1;
    chk("rc_grant", req_ready, 4'b0100);
    step();
    req_valid = 4'b1010;
    #1;
    chk("rc_calc_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rc_async_busy", busy, 0);
    chk("rc_async_valid", resp_valid, 0);
    chk("rc_async_data", resp_data, 0);
    chk("rc_async_ready", req_ready, 0);
    step();
    #1;
    chk("rc_held_valid", resp_valid, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rc_lowest_grant", req_ready, 4'b0010);
    chk("rc_no_resp", resp_valid, 0);
    step();
    req_valid = 4'h0;
    #1;
    chk("rc_no_lost_resp", resp_valid, 0);
    step();
    #1;
    chk("rc_resp_id", resp_id, 1);
    step();

    // Requester 2 drops before its turn with ptr=2, so 3 is granted and ptr wraps to 0.
    step();
    req_valid = 4'b1001;
    #1;
    chk("skip_grant3", req_ready, 4'b1000);
    step();
    step();
    #1;
    chk("skip_resp_id", resp_id, 3);
    step();
    #1;
    chk("skip_grant0", req_ready, 4'b0001);
    step();
    req_valid = 4'h0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_arbiter.md
MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the multiply-offset datapath (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, operand and result width in bits.
REQ-003 SHALL have parameter ADD_K, default 17, constant added to the truncated product.
REQ-004 SHALL have parameter SUB_K, default 21, constant subtracted after ADD_K.
REQ-005 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port REQ_VALID  input  NREQ  bit i set = requester i presents an operand pair.
REQ-008 SHALL have port REQ_A  input  NREQ*WIDTH  operand A; requester i in bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port REQ_B  input  NREQ*WIDTH  operand B; same packing as REQ_A.
REQ-010 SHALL have port REQ_READY  output  NREQ  one-hot or zero; bit i set = requester i accepted this cycle.
REQ-011 SHALL have port RESP_VALID  output  1  result available.
REQ-012 SHALL have port RESP_READY  input  1  consumer accepts the result.
REQ-013 SHALL have port RESP_DATA  output  WIDTH  computed result.
REQ-014 SHALL have port RESP_ID  output  clog2(NREQ)  index of the requester that owns RESP_DATA.
REQ-015 SHALL have port BUSY  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, CALC and HOLD.
REQ-017 In IDLE, SHALL assert REQ_READY[g] combinationally for g = the first requester with REQ_VALID set, searching upward from pointer PTR and wrapping modulo NREQ.
REQ-018 In CALC or HOLD, or when no REQ_VALID bit is set, SHALL drive REQ_READY to all zeros.
REQ-019 On acceptance (REQ_VALID[g] & REQ_READY[g]), SHALL register A[g], B[g] and g, set PTR to (g+1) mod NREQ, and go to CALC.
REQ-020 In CALC, SHALL compute RESP_DATA = (((A*B) mod 2^WIDTH) + ADD_K - SUB_K) mod 2^WIDTH, register it with RESP_ID = g, and go to HOLD.
REQ-021 The product SHALL be truncated to WIDTH bits before the constants are applied, and all intermediate results SHALL wrap modulo 2^WIDTH.
REQ-022 In HOLD, SHALL assert RESP_VALID, keeping RESP_DATA and RESP_ID stable until RESP_READY is sampled high.
REQ-023 On the RESP_VALID & RESP_READY handshake, SHALL go to IDLE; no new request SHALL be accepted in that same cycle.
REQ-024 Latency SHALL be fixed: acceptance in cycle T gives RESP_VALID in cycle T+2 (at the earliest); peak throughput is one result per 3 cycles.
REQ-025 Requesters SHALL hold REQ_A and REQ_B stable only while their REQ_VALID is high; after acceptance, later changes to the inputs SHALL NOT affect the result.
REQ-026 PTR SHALL update only on acceptance, so a requester that drops REQ_VALID before being granted is skipped without starving the others.
REQ-027 Any requester with REQ_VALID held high SHALL be granted within NREQ acceptances.
REQ-028 RESP_DATA and RESP_ID SHALL be zero whenever RESP_VALID is low.

Reset
REQ-029 While RST_N is low, regardless of CLK, SHALL set state IDLE, PTR 0, registered operands and id 0, RESP_VALID 0, RESP_DATA 0, RESP_ID 0, BUSY 0 and REQ_READY all zeros.
REQ-030 Reset asserted in CALC or HOLD SHALL discard the in-flight result with no RESP_VALID pulse; after release the FSM SHALL start in IDLE with PTR 0.

Verification
REQ-031 Requester 1 only, A=3, B=5, RESP_READY=1 -> REQ_READY=4'b0010 in cycle T; RESP_VALID in T+2 with RESP_DATA=11 and RESP_ID=1; BUSY high in T+1 and T+2.
REQ-032 Wrap cases -> A=16, B=16 gives 252; A=0, B=0 gives 252; A=255, B=255 gives 253.
REQ-033 All four REQ_VALID held high from reset, RESP_READY=1 -> grant order 0,1,2,3,0, with grants spaced exactly 3 cycles apart.
REQ-034 RESP_READY held low 5 cycles in HOLD while the inputs change -> RESP_DATA and RESP_ID stay stable, REQ_READY stays 0, and no second grant occurs until the cycle after the handshake.
REQ-035 RST_N pulsed low during CALC -> outputs zero immediately (asynchronously); no RESP_VALID for the lost request; the next grant goes to the lowest valid index.
REQ-036 Requester 2 drops REQ_VALID just before its turn, with PTR=2 and requesters 0 and 3 valid -> requester 3 is granted next and PTR becomes 0.
